// File: rtl/wifi_pkg.sv
// Shared constants for the SUPER_IO WiFi UART receive/transmit path.
// Depth default, count width and CPU status-port bit positions.
package wifi_pkg;

    localparam int WIFI_RXF_DEPTH_LOG2 = 4;
    localparam int WIFI_RXF_CNT_W      = WIFI_RXF_DEPTH_LOG2 + 1;

    localparam int ST_DATA_READY = 0;
    localparam int ST_OVERFLOW   = 1;
    localparam int ST_FRAME_ERR  = 2;
    localparam int ST_RTS_N      = 3;

endpackage

// File: rtl/wifi_rx_fifo_if.sv
// Byte-capture and CPU read-port signals of the WiFi receive FIFO.
// master drives UART/CPU strobes, slave is the FIFO.
interface wifi_rx_fifo_if
    import wifi_pkg::*;
#(
    parameter int DEPTH_LOG2 = WIFI_RXF_DEPTH_LOG2
) ();

    logic                  rx_valid;
    logic [7:0]            rx_byte;
    logic                  rx_error;
    logic                  rd_req;
    logic                  clr_status;
    logic [7:0]            rd_data;
    logic                  data_ready;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  frame_err;
    logic                  rts_n;

    modport master (
        output rx_valid,
        output rx_byte,
        output rx_error,
        output rd_req,
        output clr_status,
        input  rd_data,
        input  data_ready,
        input  count,
        input  overflow,
        input  frame_err,
        input  rts_n
    );

    modport slave (
        input  rx_valid,
        input  rx_byte,
        input  rx_error,
        input  rd_req,
        input  clr_status,
        output rd_data,
        output data_ready,
        output count,
        output overflow,
        output frame_err,
        output rts_n
    );

endinterface

// File: rtl/wifi_strobe_sync.sv
// Synchronises an asynchronous CPU port strobe and emits a one-cycle
// pulse on its falling edge (end of the CPU access).
module wifi_strobe_sync (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic pulse
);

    // sh[0..1] synchronizer, sh[2] previous synced value
    logic [2:0] sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh <= 3'b000;
        end else begin
            sh <= {sh[1:0], strobe};
        end
    end

    assign pulse = sh[2] & ~sh[1];

endmodule

// File: rtl/wifi_rx_fifo.sv
// First-word-fall-through receive FIFO behind the WiFi UART receiver.
// Optional RTS hysteresis output enabled by defining WIFI_RXF_RTS_EN.
module wifi_rx_fifo
    import wifi_pkg::*;
#(
    parameter int DEPTH_LOG2 = WIFI_RXF_DEPTH_LOG2,
    parameter int RTS_HIGH   = 12,
    parameter int RTS_LOW    = 4
) (
    input  logic           clk,
    input  logic           rst,
    wifi_rx_fifo_if.slave  bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    if (RTS_LOW >= RTS_HIGH || RTS_HIGH > DEPTH) begin : g_bad_rts
        $error("wifi_rx_fifo: RTS thresholds out of range");
    end

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt;
    logic                  ovf;
    logic                  ferr;
    logic                  pop;
    logic                  pop_ok;
    logic                  push_ok;
    logic                  good_byte;
    logic                  empty;
    logic                  full;

    wifi_strobe_sync u_rd_sync (
        .clk    (clk),
        .rst    (rst),
        .strobe (bus.rd_req),
        .pulse  (pop)
    );

    assign empty     = (cnt == '0);
    assign full      = (cnt == CW'(DEPTH));
    assign good_byte = bus.rx_valid & ~bus.rx_error;
    assign pop_ok    = pop & ~empty;
    // a pop on the same edge frees the slot a full FIFO needs
    assign push_ok   = good_byte & (~full | pop_ok);

    always_comb begin
        cnt_nxt = cnt;
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_nxt = cnt + CW'(1);
            2'b01:   cnt_nxt = cnt - CW'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            ferr   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt  <= cnt_nxt;
            ovf  <= (ovf & ~bus.clr_status) | (good_byte & ~push_ok);
            ferr <= (ferr & ~bus.clr_status) | bus.rx_error;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem[wr_ptr] <= bus.rx_byte;
        end
    end

    assign bus.rd_data    = empty ? 8'h00 : mem[rd_ptr];
    assign bus.data_ready = ~empty;
    assign bus.count      = cnt;
    assign bus.overflow   = ovf;
    assign bus.frame_err  = ferr;

`ifdef WIFI_RXF_RTS_EN
    logic rts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rts_q <= 1'b0;
        end else if (cnt_nxt >= CW'(RTS_HIGH)) begin
            rts_q <= 1'b1;
        end else if (cnt_nxt <= CW'(RTS_LOW)) begin
            rts_q <= 1'b0;
        end
    end

    assign bus.rts_n = rts_q;
`else
    assign bus.rts_n = 1'b0;
`endif

endmodule

// File: tb/tb_wifi_rx_fifo.sv
// Self-checking bench for wifi_rx_fifo against a queue-based model.
// Honours WIFI_RXF_RTS_EN for the rts_n expectation.
module tb_wifi_rx_fifo;
    import wifi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #10 clk = ~clk;

    wifi_rx_fifo_if bus ();

    wifi_rx_fifo u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    byte unsigned q[$];
    bit m_ovf;
    bit m_ferr;
    bit m_rts;
    int checks;
    int errors;

    function automatic void rts_upd();
`ifdef WIFI_RXF_RTS_EN
        if (q.size() >= 12) m_rts = 1'b1;
        else if (q.size() <= 4) m_rts = 1'b0;
`else
        m_rts = 1'b0;
`endif
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [31:0] head;
        head = (q.size() != 0) ? 32'(q[0]) : 32'h0;
        chk({tag, ".count"}, 32'(bus.count), 32'(q.size()));
        chk({tag, ".ready"}, 32'(bus.data_ready), 32'(q.size() != 0));
        chk({tag, ".data"}, 32'(bus.rd_data), head);
        chk({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
        chk({tag, ".ferr"}, 32'(bus.frame_err), 32'(m_ferr));
        chk({tag, ".rts"}, 32'(bus.rts_n), 32'(m_rts));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_ovf = 0;
        m_ferr = 0;
        m_rts = 0;
    endtask

    task automatic push(input byte unsigned b, input bit err);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        bus.rx_error = err;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
        if (err) m_ferr = 1'b1;
        else if (q.size() < 16) q.push_back(b);
        else m_ovf = 1'b1;
        rts_upd();
    endtask

    task automatic clr(input bit with_err);
        bus.clr_status = 1'b1;
        bus.rx_error   = with_err;
        @(negedge clk);
        bus.clr_status = 1'b0;
        bus.rx_error   = 1'b0;
        m_ovf  = 1'b0;
        m_ferr = with_err;
    endtask

    task automatic pop_strobe(input int len);
        bus.rd_req = 1'b1;
        repeat (len) @(negedge clk);
        check_state("strobe");
        bus.rd_req = 1'b0;
        repeat (2) @(negedge clk);
        check_state("prepop");
        @(negedge clk);
        if (q.size() != 0) void'(q.pop_front());
        rts_upd();
        check_state("pop");
    endtask

    task automatic drain(input int n);
        repeat (n) pop_strobe(int'($urandom_range(1, 6)));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.rx_valid   = 1'b0;
        bus.rx_byte    = 8'h00;
        bus.rx_error   = 1'b0;
        bus.rd_req     = 1'b0;
        bus.clr_status = 1'b0;
        @(negedge clk);
        do_reset();
        check_state("reset");

        push(8'h41, 1'b0);
        check_state("basic_push");
        pop_strobe(5);
        chk("basic_empty_data", 32'(bus.rd_data), 32'h0);

        for (int i = 0; i < 17; i++) push(8'(i), 1'b0);
        check_state("fill");
        chk("fill_ovf", 32'(bus.overflow), 32'h1);
        drain(16);

        for (int i = 0; i < 10; i++) push(8'(8'hA0 + i), 1'b0);
        drain(10);
        for (int i = 0; i < 12; i++) push(8'(8'hA0 + i), 1'b0);
        check_state("wrap_fill");
        drain(12);
        chk("wrap_count", 32'(bus.count), 32'h0);

        clr(1'b0);
        check_state("clr");
        for (int i = 0; i < 16; i++) push(8'($urandom), 1'b0);
        check_state("full");
        bus.rd_req = 1'b1;
        repeat (2) @(negedge clk);
        bus.rd_req = 1'b0;
        repeat (2) @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = 8'h55;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        void'(q.pop_front());
        q.push_back(8'h55);
        rts_upd();
        check_state("full_pushpop");
        drain(15);
        chk("last_out", 32'(bus.rd_data), 32'h55);
        drain(1);

        clr(1'b1);
        check_state("clr_vs_err");
        chk("clr_vs_err_ferr", 32'(bus.frame_err), 32'h1);
        clr(1'b0);
        check_state("clr_only");

        for (int i = 0; i < 7; i++) push(8'($urandom), 1'b0);
        push(8'h00, 1'b1);
        check_state("pre_rst");
        do_reset();
        check_state("mid_rst");
        push(8'h7E, 1'b0);
        chk("post_rst_data", 32'(bus.rd_data), 32'h7E);
        drain(1);

        do_reset();
        for (int i = 0; i < 12; i++) push(8'($urandom), 1'b0);
        check_state("rts_12");
        drain(7);
        check_state("rts_5");
        drain(1);
        check_state("rts_4");
        drain(4);

        for (int i = 0; i < 80; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 4) begin
                push(8'($urandom), 1'b0);
                check_state("rnd_push");
            end else if (r <= 7) begin
                pop_strobe(int'($urandom_range(1, 6)));
            end else if (r == 8) begin
                push(8'($urandom), 1'b1);
                check_state("rnd_err");
            end else begin
                clr(1'b0);
                check_state("rnd_clr");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wifi_rx_fifo.md
Name: wifi_rx_fifo

Overview:
Receive-side buffer directly downstream of the WiFi UART receiver on the SUPER_IO board. Captures each completed byte (one-cycle `received` pulse plus `rx_byte`) into a small first-word-fall-through FIFO. Presents the head byte and status to the Z80/S100 port-read logic. Pops on the trailing edge of a CPU port-read strobe, so a 115200-baud burst survives CPU latency without losing bytes.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (depth 16)
RTS_HIGH, 12, occupancy at or above which flow-control deasserts (RTS feature only)
RTS_LOW, 4, occupancy at or below which flow-control reasserts (RTS feature only)

Ports:
clk  in  1  master clock, 50 MHz
rst  in  1  reset, synchronous, active-high
rx_valid  in  1  one-cycle pulse: UART byte received
rx_byte  in  8  UART byte, valid when rx_valid=1
rx_error  in  1  one-cycle pulse: UART framing error
rd_req  in  1  CPU data-port read strobe, asynchronous, active-high, held for multiple clk cycles
clr_status  in  1  one-cycle pulse: clear sticky flags
rd_data  out  8  head-of-FIFO byte; 0x00 when empty
data_ready  out  1  FIFO non-empty
count  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: byte dropped because FIFO was full
frame_err  out  1  sticky: rx_error seen
rts_n  out  1  flow control to WiFi module, active-low (RTS feature only)

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - wr_ptr=rd_ptr=0, count=0, data_ready=0, overflow=0, frame_err=0, rts_n=0.
  - rd_req synchronizer flops cleared to 0.
  - Memory contents are not reset.
  - Reset mid-burst discards all buffered bytes. The first rx_valid after reset release is stored at index 0.
- rd_req path:
  - 2-flop synchronizer, then a third flop for edge detect.
  - pop = synced_prev & ~synced, i.e. falling edge: the end of the CPU read.
  - rd_data is therefore stable for the whole CPU read.
  - Pop latency: 3 clk edges after rd_req falls. Exactly one pop per strobe, regardless of strobe length.
- Push:
  - On rx_valid=1: if count<DEPTH, or a pop occurs in the same cycle, write mem[wr_ptr]=rx_byte and wr_ptr+=1.
  - Otherwise drop the byte and set overflow.
- Pop:
  - If count>0: rd_ptr+=1.
  - Pop when empty is ignored, with no flag.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - Full + pop + push: the new byte is accepted.
  - Empty + push + pop: the pop is ignored and the push is accepted, so count becomes 1.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. count is tracked separately; full is count==DEPTH.
- Read path:
  - rd_data = mem[rd_ptr] when count!=0, else 0x00 (combinational from registers).
  - A byte pushed at edge N is visible on rd_data / data_ready after edge N.
- Sticky flags:
  - rx_error sets frame_err; the errored byte is not pushed.
  - clr_status clears overflow and frame_err.
  - A set event in the same cycle as clr_status wins: the flag ends at 1.
- Flags are registered; count and data_ready are updated on the same edge as the pointers.

Optional Feature:
WIFI_RXF_RTS_EN:
- Defined: rts_n is a registered hysteresis output.
  - Set to 1 when next count >= RTS_HIGH.
  - Cleared to 0 when next count <= RTS_LOW.
  - Otherwise holds. Reset value 0.
- Not defined: rts_n port is still present, tied to 0 (always clear-to-send), and no hysteresis logic is built.

Decomposition:
- Shared package wifi_pkg holds:
  - WIFI_RXF_DEPTH_LOG2 default.
  - Status-bit index constants for the CPU status port: bit0 data_ready, bit1 overflow, bit2 frame_err, bit3 rts_n.
  - Width localparam for count.
- One sub-module: wifi_strobe_sync. 2-flop synchronizer plus falling-edge detector, 1-bit in, 1-cycle pulse out, sync reset. It is reused later for the TX port-write strobe.

Test Plan:
- Reset/basic:
  - Stimulus: after rst, push 0x41, then one rd_req held 5 cycles.
  - Required: data_ready=1 and rd_data=0x41 during the strobe; 3 cycles after rd_req falls, count=0, data_ready=0, rd_data=0x00.
- Fill and overflow:
  - Stimulus: push 0x00..0x10 (17 bytes), no reads.
  - Required: count=16, overflow=1; draining yields 0x00..0x0F in order, and 0x10 is lost.
- Wrap-around:
  - Stimulus: push 10, pop 10, push 12, pop 12 with values 0xA0..0xAB.
  - Required: order preserved across the pointer wrap; count returns to 0.
- Simultaneous events, full case:
  - Stimulus: with count=16, time rx_valid(0x55) to coincide with the pop pulse.
  - Required: count stays 16, overflow stays 0, and 0x55 is last out.
- Simultaneous events, flag clear:
  - Stimulus: clr_status coincident with rx_error.
  - Required: frame_err=1.
- Reset mid-operation:
  - Stimulus: count=7, then rst for 1 cycle.
  - Required: count=0, overflow=0, frame_err=0; the next pushed byte 0x7E appears on rd_data.
- RTS (WIFI_RXF_RTS_EN defined):
  - Stimulus: push 12 bytes.
  - Required: rts_n=1 after the 12th push edge; it stays 1 while popping down to 5 and returns to 0 when count reaches 4.
  - Stimulus: same sequence with the macro undefined.
  - Required: rts_n=0 throughout.
